// File: rtl/barrel_shift.sv
// Logarithmic barrel shifter with a combinational result and a registered copy.
// Built from cascaded fixed-distance 2:1 mux stages, one stage per shift-amount bit.
module barrel_shift #(
  parameter  int LENGTH = 8,
  parameter  bit LEFT   = 1'b1,
  localparam int SAW    = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LENGTH-1:0] data_in,
  input  logic [SAW-1:0]    shamt,
  output logic [LENGTH-1:0] data_out,
  output logic [LENGTH-1:0] data_out_q
);

  // stage[k] is the operand after the first k mux stages have been applied
  logic [SAW:0][LENGTH-1:0] stage;
  logic [LENGTH-1:0]        data_out_d;

  assign stage[0] = data_in;

  for (genvar k = 0; k < SAW; k++) begin : g_stage
    localparam int STEP = 2 ** k;
    logic [LENGTH-1:0] moved;

    if (LEFT) begin : g_left
      assign moved = {stage[k][LENGTH-1-STEP:0], {STEP{1'b0}}};
    end else begin : g_right
      assign moved = {{STEP{1'b0}}, stage[k][LENGTH-1:STEP]};
    end

    // The conditional operator merges both candidates on an unknown select,
    // so X/Z on shamt[k] shows up as X exactly on the bits that would differ.
    assign stage[k+1] = shamt[k] ? moved : stage[k];
  end

  // Amounts of LENGTH or more clear the word naturally: the cumulative
  // stage distances push every bit out.
  assign data_out = stage[SAW];

  always_comb begin
    data_out_d = data_out;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_barrel_shift.sv
// Self-checking bench for barrel_shift: directed vectors, register/reset
// sequences and a randomized comparison against an arithmetic reference.
module tb_barrel_shift;

  logic clk;
  logic reset;

  logic [7:0] din_l8, out_l8, q_l8;
  logic [2:0] sh_l8;
  logic [7:0] din_r8, out_r8, q_r8;
  logic [2:0] sh_r8;
  logic [5:0] din_l6, out_l6, q_l6;
  logic [2:0] sh_l6;

  int checks   = 0;
  int failures = 0;

  barrel_shift #(.LENGTH(8), .LEFT(1'b1)) u_l8 (
    .clk(clk), .reset(reset), .data_in(din_l8), .shamt(sh_l8),
    .data_out(out_l8), .data_out_q(q_l8)
  );

  barrel_shift #(.LENGTH(8), .LEFT(1'b0)) u_r8 (
    .clk(clk), .reset(reset), .data_in(din_r8), .shamt(sh_r8),
    .data_out(out_r8), .data_out_q(q_r8)
  );

  barrel_shift #(.LENGTH(6), .LEFT(1'b1)) u_l6 (
    .clk(clk), .reset(reset), .data_in(din_l6), .shamt(sh_l6),
    .data_out(out_l6), .data_out_q(q_l6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: 10^6 clock periods.
  initial begin
    #10_000_000;
    $display("FAIL timeout: simulation still running after 1000000 clock periods");
    $fatal(1, "timeout");
  end

  typedef struct {
    int         unit;  // 0: LENGTH=8 left, 1: LENGTH=8 right, 2: LENGTH=6 left
    logic [7:0] din;
    logic [2:0] sh;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply(input int unit, input logic [7:0] d, input logic [2:0] s);
    case (unit)
      0:       begin din_l8 = d;      sh_l8 = s; end
      1:       begin din_r8 = d;      sh_r8 = s; end
      default: begin din_l6 = d[5:0]; sh_l6 = s; end
    endcase
  endtask

  function automatic logic [7:0] get_out(input int unit);
    case (unit)
      0:       return out_l8;
      1:       return out_r8;
      default: return {2'b00, out_l6};
    endcase
  endfunction

  // Reference: a left shift multiplies by 2^s modulo 2^len, a logical right
  // shift divides by 2^s with truncation.
  function automatic logic [7:0] ref_shift(input int len, input bit left,
                                           input logic [7:0] d, input logic [2:0] s);
    longint unsigned mod, v, p;
    mod = longint'(2) ** len;
    p   = longint'(2) ** int'(s);
    v   = longint'(d) % mod;
    v   = left ? (v * p) % mod : v / p;
    return v[7:0];
  endfunction

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{0, 8'b0010_0100, 3'd0, 8'b0010_0100},
      '{0, 8'b0010_0100, 3'd1, 8'b0100_1000},
      '{0, 8'b0010_0100, 3'd2, 8'b1001_0000},
      '{0, 8'b0010_0100, 3'd3, 8'b0010_0000},
      '{0, 8'b0010_0100, 3'd4, 8'b0100_0000},
      '{0, 8'b0010_0100, 3'd5, 8'b1000_0000},
      '{0, 8'b0010_0100, 3'd6, 8'b0000_0000},
      '{0, 8'b0010_0100, 3'd7, 8'b0000_0000},
      '{0, 8'hFF,        3'd7, 8'h80},
      '{0, 8'hFF,        3'd0, 8'hFF},
      '{1, 8'h96,        3'd4, 8'h09},
      '{1, 8'h80,        3'd7, 8'h01},
      '{1, 8'hFF,        3'd0, 8'hFF},
      '{2, 8'b00_0011,   3'd5, 8'b0010_0000},
      '{2, 8'b00_0011,   3'd6, 8'h00},
      '{2, 8'b00_0011,   3'd7, 8'h00},
      '{2, 8'b11_1111,   3'd0, 8'h3F}
    };

    reset = 1'b0;
    apply(0, 8'h00, 3'd0);
    apply(1, 8'h00, 3'd0);
    apply(2, 8'h00, 3'd0);

    // Reset state: registers clear, combinational path stays live.
    apply(0, 8'h05, 3'd1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_q_l8", q_l8, 8'h00);
    check("reset_q_r8", q_r8, 8'h00);
    check("reset_q_l6", {2'b00, q_l6}, 8'h00);
    check("reset_comb_live", out_l8, 8'h0A);

    // Release away from an edge; first edge sampled high loads the register.
    @(negedge clk);
    reset = 1'b1;
    apply(0, 8'h0F, 3'd2);
    @(posedge clk);
    #1;
    check("reg_load", q_l8, 8'h3C);
    apply(0, 8'h01, 3'd0);
    #2;
    check("reg_hold_comb", out_l8, 8'h01);
    check("reg_hold", q_l8, 8'h3C);
    apply(0, 8'h0F, 3'd2);
    #1;

    // Mid-cycle async reset with a capture value sitting on the D side.
    reset = 1'b0;
    #1;
    check("async_clear_q", q_l8, 8'h00);
    check("async_clear_comb", out_l8, 8'h3C);
    @(posedge clk);
    #1;
    check("held_in_reset", q_l8, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("no_load_before_edge", q_l8, 8'h00);
    @(posedge clk);
    #1;
    check("reload_after_release", q_l8, 8'h3C);

    // Directed combinational vectors.
    foreach (vecs[i]) begin
      apply(vecs[i].unit, vecs[i].din, vecs[i].sh);
      #2;
      check($sformatf("vec%0d_u%0d", i, vecs[i].unit), get_out(vecs[i].unit), vecs[i].exp);
    end

    // Random combinational regression on all three configurations.
    for (int i = 0; i < 10000; i++) begin
      logic [7:0] d0, d1, d2;
      logic [2:0] s0, s1, s2;
      d0 = 8'($urandom); s0 = 3'($urandom);
      d1 = 8'($urandom); s1 = 3'($urandom);
      d2 = 8'($urandom_range(0, 63)); s2 = 3'($urandom);
      apply(0, d0, s0);
      apply(1, d1, s1);
      apply(2, d2, s2);
      #1;
      check($sformatf("rnd_l8 d=%h s=%0d", d0, s0), out_l8, ref_shift(8, 1'b1, d0, s0));
      check($sformatf("rnd_r8 d=%h s=%0d", d1, s1), out_r8, ref_shift(8, 1'b0, d1, s1));
      check($sformatf("rnd_l6 d=%h s=%0d", d2, s2), {2'b00, out_l6}, ref_shift(6, 1'b1, d2, s2));
    end

    // Random registered path: each edge captures the value set up before it.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] d0, d1;
      logic [2:0] s0, s1;
      @(negedge clk);
      d0 = 8'($urandom); s0 = 3'($urandom);
      d1 = 8'($urandom); s1 = 3'($urandom);
      apply(0, d0, s0);
      apply(1, d1, s1);
      @(posedge clk);
      #1;
      check($sformatf("rnd_q_l8 d=%h s=%0d", d0, s0), q_l8, ref_shift(8, 1'b1, d0, s0));
      check($sformatf("rnd_q_r8 d=%h s=%0d", d1, s1), q_r8, ref_shift(8, 1'b0, d1, s1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrel_shift.md
BARREL_SHIFT -- requirements
Module: barrel_shift

Interface
REQ-001 Parameter LENGTH, default 8, data width in bits; SHALL be at least 2.
REQ-002 Parameter LEFT, default 1, shift direction: 1 = shift left, 0 = shift right (logical).
REQ-003 SAW = $clog2(LENGTH) SHALL be the shift-amount width.
REQ-004 clk  input  1  single clock; all sequential logic SHALL use its rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-low.
REQ-006 data_in  input  LENGTH  operand to shift.
REQ-007 shamt  input  SAW  unsigned shift amount.
REQ-008 data_out  output  LENGTH  combinational shift result.
REQ-009 data_out_q  output  LENGTH  data_out registered on the rising edge of clk.

Function
REQ-010 With LEFT=1, data_out SHALL equal data_in << shamt, truncated to LENGTH bits, with zeros filling the vacated LSBs.
REQ-011 With LEFT=0, data_out SHALL equal data_in >> shamt, with zeros filling the vacated MSBs; there SHALL be no sign extension.
REQ-012 data_out SHALL be purely combinational with zero-cycle latency, settle within the same time step as an input change, and not depend on clk or reset.
REQ-013 shamt = 0 SHALL give data_out = data_in.
REQ-014 shamt >= LENGTH (possible only when LENGTH is not a power of 2) SHALL give data_out = 0.
REQ-015 The shifter SHALL be built as SAW cascaded 2:1 mux stages; stage k SHALL shift by 2^k when shamt[k] = 1 and pass data through otherwise.
REQ-016 No shift operator SHALL be applied to a variable amount in the datapath.
REQ-017 X or Z on any shamt bit SHALL propagate X to the affected output bits; inputs SHALL NOT be silently resolved.
REQ-018 On each rising clk edge while reset is high, data_out_q SHALL load the current data_out value, giving one cycle of latency.
REQ-019 data_out_q SHALL update on every edge; there is no enable or handshake.
REQ-020 The block SHALL have no other state.

Reset
REQ-021 While reset is low, data_out_q SHALL be 0, asserted asynchronously without waiting for a clock edge.
REQ-022 When reset is released, data_out_q SHALL load data_out on the first rising edge of clk at which reset is sampled high.
REQ-023 reset SHALL NOT affect data_out; the combinational path stays live during reset.
REQ-024 Asserting reset between clock edges SHALL clear data_out_q immediately; a capture in flight is discarded.

Verification (LENGTH=8, LEFT=1 unless stated)
REQ-025 Sweep: data_in = 8'b00100100, shamt stepped 0..7, check 2 time units after each change -> data_out = data_in << shamt each step, e.g. shamt=3 gives 8'b00100000.
REQ-026 Truncation: data_in = 8'hFF, shamt = 7 -> data_out = 8'h80; shamt = 0 -> data_out = 8'hFF.
REQ-027 Right shift (LEFT=0): data_in = 8'h96, shamt = 4 -> data_out = 8'h09; data_in = 8'h80, shamt = 7 -> data_out = 8'h01 (no sign fill).
REQ-028 Registered path: with reset high, set data_in = 8'h0F, shamt = 2 before a rising edge -> data_out_q = 8'h3C after that edge, and it holds until the next edge.
REQ-029 Reset: drive reset low mid-cycle with data_out_q = 8'h3C -> data_out_q = 0 immediately while data_out stays 8'h3C; release reset -> data_out_q = 8'h3C after the next rising edge.
REQ-030 Non-power-of-2 (LENGTH=6, LEFT=1): data_in = 6'b000011, shamt = 5 -> data_out = 6'b100000; shamt = 6 and shamt = 7 -> data_out = 0.
REQ-031 Random regression: at least 10^4 random (data_in, shamt) pairs in both LEFT settings SHALL match the reference shift operator, with a timeout of 10^6 clock periods.
